gate_sweep_checker: RTL and testbench



---
 rtl/gate_sweep_checker.sv | 136 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_checker.sv
// In-system checker for the two-input gate set: sweeps a/b through 00..11, samples
// the seven gate outputs after a settle delay and reports pass, fail mask and count.
// Optional first-failure capture is enabled with `define GATE_SWEEP_LOG_EN.

module gate_sweep_expect (
    input  logic       a,
    input  logic       b,
    output logic [6:0] expected
);
    // Bit order matches gate_out: xnor, xor, nor, nand, not(a), or, and.
    assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
endmodule

module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask,
    output logic [1:0] first_fail_idx,
    output logic [6:0] first_fail_obs
);
    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic [6:0] expected;
    logic       accept, settled, last_vec, mismatch;

    assign accept   = (state == IDLE) && start;
    assign settled  = (cnt == CNT_LAST);
    assign last_vec = (idx == 2'd3);

    // Stimulus is the vector index itself, so a/b are register outputs.
    assign a = idx[1];
    assign b = idx[0];

    gate_sweep_expect u_expect (
        .a        (a),
        .b        (b),
        .expected (expected)
    );

    assign mismatch = (gate_out != expected);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE:  if (settled) state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? DONE : SETTLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            cnt       <= 4'd0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= 2'd0;
                        cnt       <= 4'd0;
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!settled) cnt <= cnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_mask[idx] <= 1'b1;
                        err_count      <= err_count + 3'd1;
                    end
                    // Fold the last vector's result in so pass is valid during DONE.
                    if (last_vec) begin
                        pass <= (err_count == 3'd0) && !mismatch;
                    end else begin
                        idx <= idx + 2'd1;
                        cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_SWEEP_LOG_EN
    // err_count still zero means this CHECK is the sweep's first failure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_fail_idx <= 2'd0;
            first_fail_obs <= 7'd0;
        end else if (accept) begin
            first_fail_idx <= 2'd0;
            first_fail_obs <= 7'd0;
        end else if ((state == CHECK) && mismatch && (err_count == 3'd0)) begin
            first_fail_idx <= idx;
            first_fail_obs <= gate_out;
        end
    end
`else
    assign first_fail_idx = 2'd0;
    assign first_fail_obs = 7'd0;
`endif

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Randomized self-checking bench for gate_sweep_checker against a vector-level model.
module tb_gate_sweep_checker;
    localparam int S   = 2;
    localparam int LAT = 4 * (S + 1);

    logic       clk = 1'b0;
    logic       rst, start;
    logic [6:0] gate_out;
    logic       a, b, busy, done, pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;
    logic [1:0] first_fail_idx;
    logic [6:0] first_fail_obs;

    int         mode;
    logic [6:0] vmask [4];
    int         passed = 0;
    int         total  = 0;

    gate_sweep_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_out(gate_out),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_mask(fail_mask),
        .first_fail_idx(first_fail_idx), .first_fail_obs(first_fail_obs)
    );

    always #5 clk = ~clk;

    // Truth table from arithmetic on the input values.
    function automatic logic [6:0] truth(logic [1:0] v);
        int x, y;
        logic [6:0] t;
        x = int'(v[1]);
        y = int'(v[0]);
        t[0] = (x * y) == 1;
        t[1] = (x + y) > 0;
        t[2] = x == 0;
        t[3] = (x * y) == 0;
        t[4] = (x + y) == 0;
        t[5] = (x + y) == 1;
        t[6] = (x + y) != 1;
        return t;
    endfunction

    // 0 correct, 1 xor stuck-at-0, 2 all inverted, 3 per-vector random flips.
    function automatic logic [6:0] observed(int m, logic [1:0] v);
        case (m)
            1:       return truth(v) & 7'b1011111;
            2:       return ~truth(v);
            3:       return truth(v) ^ vmask[v];
            default: return truth(v);
        endcase
    endfunction

    always_comb gate_out = observed(mode, {a, b});

    task automatic run_sweep(input string name);
        logic [3:0] e_mask = 4'd0;
        logic [2:0] e_err  = 3'd0;
        logic [1:0] e_fidx = 2'd0;
        logic [6:0] e_fobs = 7'd0;
        logic [1:0] e_ab;
        int ab_bad = 0, busy_bad = 0, done_bad = 0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv = 2'(v);
            if (observed(mode, vv) != truth(vv)) begin
                if (e_err == 3'd0) begin
                    e_fidx = vv;
                    e_fobs = observed(mode, vv);
                end
                e_mask[v] = 1'b1;
                e_err++;
            end
        end
`ifndef GATE_SWEEP_LOG_EN
        e_fidx = 2'd0;
        e_fobs = 7'd0;
`endif
        @(negedge clk) start = 1'b1;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(negedge clk);
            start = 1'b0;
            e_ab = (k < LAT) ? 2'(k / (S + 1)) : 2'b11;
            if ({a, b} !== e_ab) ab_bad++;
            if (busy !== (k < LAT)) busy_bad++;
            if (done !== (k == LAT)) done_bad++;
            if (k == LAT) begin
                total++;
                if ({pass, err_count, fail_mask} !== {e_err == 3'd0, e_err, e_mask})
                    $display("FAIL %s result: pass=%b err=%0d mask=%b, want pass=%b err=%0d mask=%b",
                             name, pass, err_count, fail_mask, e_err == 3'd0, e_err, e_mask);
                else passed++;
                total++;
                if ({first_fail_idx, first_fail_obs} !== {e_fidx, e_fobs})
                    $display("FAIL %s first_fail: idx=%0d obs=%b, want idx=%0d obs=%b",
                             name, first_fail_idx, first_fail_obs, e_fidx, e_fobs);
                else passed++;
            end
        end
        total++;
        if (pass !== (e_err == 3'd0))
            $display("FAIL %s pass_hold: pass=%b want %b", name, pass, e_err == 3'd0);
        else passed++;
        total++;
        if ({ab_bad, busy_bad, done_bad} !== {32'd0, 32'd0, 32'd0})
            $display("FAIL %s timing: bad cycles ab=%0d busy=%0d done=%0d, want 0/0/0",
                     name, ab_bad, busy_bad, done_bad);
        else passed++;
    endtask

    task automatic test_reset();
        int busy_seen = 0;
        rst = 1'b1; start = 1'b0; mode = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({a, b, busy, done, pass, err_count, fail_mask, first_fail_idx, first_fail_obs} !== 23'd0)
            $display("FAIL reset_values: got %b, want all zero",
                     {a, b, busy, done, pass, err_count, fail_mask, first_fail_idx, first_fail_obs});
        else passed++;
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy || done) busy_seen++;
        end
        total++;
        if (busy_seen !== 0) $display("FAIL idle_no_start: %0d active cycles, want 0", busy_seen);
        else passed++;
    endtask

    task automatic test_clean();
        mode = 0;
        run_sweep("clean");
    endtask

    task automatic test_xor_stuck();
        mode = 1;
        run_sweep("xor_stuck");
    endtask

    task automatic test_inverted();
        mode = 2;
        run_sweep("inverted");
    endtask

    task automatic test_random_faults();
        mode = 3;
        for (int n = 0; n < 6; n++) begin
            for (int v = 0; v < 4; v++)
                vmask[v] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
            run_sweep("random");
        end
    endtask

    task automatic test_reset_mid_sweep();
        int act = 0;
        mode = 2;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k <= 2 * (S + 1); k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({a, b, fail_mask, busy} !== {2'b10, 4'b0011, 1'b1})
            $display("FAIL mid_pre: ab=%b mask=%b busy=%b, want ab=10 mask=0011 busy=1",
                     {a, b}, fail_mask, busy);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({a, b, busy, done, fail_mask, err_count} !== 11'd0)
            $display("FAIL mid_reset: ab=%b busy=%b done=%b mask=%b err=%0d, want all zero",
                     {a, b}, busy, done, fail_mask, err_count);
        else passed++;
        @(negedge clk) rst = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (busy || done) act++;
        end
        total++;
        if (act !== 0) $display("FAIL mid_no_done: %0d active cycles after reset, want 0", act);
        else passed++;
        mode = 0;
        run_sweep("after_reset");
    endtask

    task automatic test_start_held();
        int dones = 0;
        mode = 2;
        @(negedge clk) start = 1'b1;
        for (int k = 0; k <= 2 * LAT + 4; k++) begin
            @(negedge clk);
            if (done) dones++;
            if (k == LAT + 1) begin
                total++;
                if ({busy, err_count} !== {1'b0, 3'd4})
                    $display("FAIL held_idle: busy=%b err=%0d, want busy=0 err=4", busy, err_count);
                else passed++;
            end
            if (k == LAT + 2) begin
                mode = 0;
                total++;
                if ({busy, a, b, err_count, fail_mask, pass} !== {1'b1, 2'b00, 3'd0, 4'd0, 1'b0})
                    $display("FAIL held_restart: busy=%b ab=%b err=%0d mask=%b pass=%b, want 1 00 0 0000 0",
                             busy, {a, b}, err_count, fail_mask, pass);
                else passed++;
            end
            if (k == 2 * LAT + 2) begin
                total++;
                if ({done, pass, err_count, fail_mask} !== {1'b1, 1'b1, 3'd0, 4'd0})
                    $display("FAIL held_second: done=%b pass=%b err=%0d mask=%b, want 1 1 0 0000",
                             done, pass, err_count, fail_mask);
                else passed++;
                start = 1'b0;
            end
        end
        total++;
        if ({dones, busy} !== {32'd2, 1'b0})
            $display("FAIL held_count: dones=%0d busy=%b, want 2 and 0", dones, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        mode = 1;
        run_sweep("b2b_fail");
        mode = 0;
        run_sweep("b2b_clean");
    endtask

    initial begin
        for (int v = 0; v < 4; v++) vmask[v] = 7'd0;
        test_reset();
        test_clean();
        test_xor_stuck();
        test_inverted();
        test_random_faults();
        test_reset_mid_sweep();
        test_start_held();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
